// File: rtl/dsa_pkg.sv
// Shared types and constants for the bilinear SIMD fetch sequencer.
package dsa_pkg;

  localparam int FRAC_BITS   = 8;
  localparam int NB_PER_LANE = 4;

  typedef enum logic [2:0] {
    IDLE,
    ROW_SETUP,
    FETCH,
    DRAIN,
    LOAD,
    ADVANCE,
    DONE
  } fetch_state_t;

  typedef enum logic [1:0] {
    P00,
    P01,
    P10,
    P11
  } nbr_t;

endpackage

// File: rtl/dsa_coord_gen.sv
// One axis of the source-coordinate mapping: index*scale split into a
// clamped integer neighbour pair and the fractional weight.
module dsa_coord_gen #(
  parameter int DW   = 10,
  parameter int SW   = 16,
  parameter int FRAC = 8
) (
  input  logic [DW-1:0]   idx,
  input  logic [SW-1:0]   scale,
  input  logic [DW-1:0]   size,
  output logic [DW-1:0]   i0,
  output logic [DW-1:0]   i1,
  output logic [FRAC-1:0] frac
);

  localparam int PW = DW + SW;
  localparam int IW = PW - FRAC;

  logic [PW-1:0] pos;
  logic [IW-1:0] ipart;
  logic [DW-1:0] last;

  assign pos   = PW'(idx) * PW'(scale);
  assign ipart = pos[PW-1:FRAC];
  assign last  = size - DW'(1);

  // Both neighbours clamp to the last column/row so edge pixels replicate.
  assign i0   = (ipart > IW'(last)) ? last : ipart[DW-1:0];
  assign i1   = (i0 < last) ? i0 + DW'(1) : last;
  assign frac = pos[FRAC-1:0];

endmodule

// File: rtl/dsa_simd_fetch_ctrl.sv
// Walks the destination image N pixels at a time, fetches the four source
// neighbours of each lane into staging registers and hands groups to the SIMD bank.
module dsa_simd_fetch_ctrl
  import dsa_pkg::*;
#(
  parameter int N    = 4,
  parameter int AW   = 16,
  parameter int DW   = 10,
  parameter int FRAC = FRAC_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DW-1:0]          src_w,
  input  logic [DW-1:0]          src_h,
  input  logic [DW-1:0]          dst_w,
  input  logic [DW-1:0]          dst_h,
  input  logic [15:0]            scale_x,
  input  logic [15:0]            scale_y,
  input  logic [AW-1:0]          base_addr,
  output logic                   mem_rd_en,
  output logic [AW-1:0]          mem_addr,
  input  logic [7:0]             mem_rdata,
  output logic [N-1:0][7:0]      stg_p00,
  output logic [N-1:0][7:0]      stg_p01,
  output logic [N-1:0][7:0]      stg_p10,
  output logic [N-1:0][7:0]      stg_p11,
  output logic [N-1:0][FRAC-1:0] stg_fx,
  output logic [N-1:0][FRAC-1:0] stg_fy,
  output logic [N-1:0]           lane_valid,
  input  logic                   simd_ready,
  output logic                   load_en,
  output logic                   busy,
  output logic                   done
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  fetch_state_t state;
  logic [DW-1:0] src_w_q, src_h_q, dst_w_q, dst_h_q, x0, y;
  logic [15:0]   scale_x_q, scale_y_q;
  logic [AW-1:0] base_q, row0, row1;
  logic [FRAC-1:0] fy_q;
  logic [LW-1:0] lane, rd_lane;
  nbr_t          nbr, rd_nbr;
  logic          rd_pend;
  logic [NB_PER_LANE-1:0][N-1:0][7:0] stg_p;

  logic [DW-1:0]   x_idx, ix0, ix1, iy0, iy1;
  logic [FRAC-1:0] fx, fy;
  logic [DW:0]     x_next, x0_step, y_step;
  logic            more_lanes;
  logic [AW-1:0]   row_sel, col_sel;

  assign x_idx = x0 + DW'(lane);

  dsa_coord_gen #(.DW(DW), .SW(16), .FRAC(FRAC)) u_coord_x (
    .idx(x_idx), .scale(scale_x_q), .size(src_w_q), .i0(ix0), .i1(ix1), .frac(fx)
  );

  dsa_coord_gen #(.DW(DW), .SW(16), .FRAC(FRAC)) u_coord_y (
    .idx(y), .scale(scale_y_q), .size(src_h_q), .i0(iy0), .i1(iy1), .frac(fy)
  );

  // Valid lanes always form a prefix of the group, so the first invalid lane ends the fetch.
  assign x_next     = (DW+1)'(x_idx) + (DW+1)'(1);
  assign more_lanes = (lane != LW'(N-1)) && (x_next < {1'b0, dst_w_q});
  assign x0_step    = (DW+1)'(x0) + (DW+1)'(N);
  assign y_step     = (DW+1)'(y) + (DW+1)'(1);

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    row_sel = (nbr == P10 || nbr == P11) ? row1 : row0;
    col_sel = (nbr == P00 || nbr == P10) ? AW'(ix0) : AW'(ix1);
  end

  // Read strobe and load pulse decode straight from state so they share its cycle.
  assign mem_rd_en = (state == FETCH);
  assign mem_addr  = mem_rd_en ? base_q + row_sel + col_sel : '0;
  assign load_en   = (state == LOAD) && simd_ready;

  assign stg_p00 = stg_p[P00];
  assign stg_p01 = stg_p[P01];
  assign stg_p10 = stg_p[P10];
  assign stg_p11 = stg_p[P11];

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      src_w_q    <= '0;
      src_h_q    <= '0;
      dst_w_q    <= '0;
      dst_h_q    <= '0;
      scale_x_q  <= '0;
      scale_y_q  <= '0;
      base_q     <= '0;
      x0         <= '0;
      y          <= '0;
      row0       <= '0;
      row1       <= '0;
      fy_q       <= '0;
      lane       <= '0;
      nbr        <= P00;
      rd_lane    <= '0;
      rd_nbr     <= P00;
      rd_pend    <= 1'b0;
      stg_p      <= '0;
      stg_fx     <= '0;
      stg_fy     <= '0;
      lane_valid <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (rd_pend) stg_p[rd_nbr][rd_lane] <= mem_rdata;
      rd_pend <= 1'b0;
      done    <= 1'b0;

      case (state)
        IDLE: if (start) begin
          src_w_q    <= src_w;
          src_h_q    <= src_h;
          dst_w_q    <= dst_w;
          dst_h_q    <= dst_h;
          scale_x_q  <= scale_x;
          scale_y_q  <= scale_y;
          base_q     <= base_addr;
          x0         <= '0;
          y          <= '0;
          lane       <= '0;
          nbr        <= P00;
          stg_p      <= '0;
          stg_fx     <= '0;
          stg_fy     <= '0;
          lane_valid <= '0;
          if (dst_w == '0 || dst_h == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            busy  <= 1'b1;
            state <= ROW_SETUP;
          end
        end

        ROW_SETUP: begin
          row0  <= AW'((2*DW)'(iy0) * (2*DW)'(src_w_q));
          row1  <= AW'((2*DW)'(iy1) * (2*DW)'(src_w_q));
          fy_q  <= fy;
          state <= FETCH;
        end

        FETCH: begin
          rd_pend          <= 1'b1;
          rd_lane          <= lane;
          rd_nbr           <= nbr;
          lane_valid[lane] <= 1'b1;
          stg_fx[lane]     <= fx;
          stg_fy[lane]     <= fy_q;
          if (nbr == P11) begin
            nbr <= P00;
            if (more_lanes) begin
              lane <= lane + LW'(1);
            end else begin
              lane  <= '0;
              state <= DRAIN;
            end
          end else begin
            nbr <= nbr_t'(nbr + 2'd1);
          end
        end

        DRAIN: state <= LOAD;

        LOAD: if (simd_ready) state <= ADVANCE;

        ADVANCE: begin
          stg_p      <= '0;
          stg_fx     <= '0;
          stg_fy     <= '0;
          lane_valid <= '0;
          if (x0_step >= {1'b0, dst_w_q}) begin
            x0 <= '0;
            y  <= y_step[DW-1:0];
            if (y_step == {1'b0, dst_h_q}) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= ROW_SETUP;
            end
          end else begin
            x0    <= x0_step[DW-1:0];
            state <= FETCH;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dsa_simd_fetch_ctrl.md
# dsa_simd_fetch_ctrl

Sequencer that feeds the SIMD pixel-register bank of the bilinear interpolation datapath. It walks the destination image in groups of N horizontally adjacent output pixels and computes each lane's source coordinates and fractions. It fetches the four neighbour pixels (p00, p01, p10, p11) per lane from a single-port source memory into staging registers, then pulses `load_en` to the SIMD register bank when downstream is ready.

## Interface
- `N`, 4, lanes per group (≥1)
- `AW`, 16, source memory address width
- `DW`, 10, image dimension width
- `FRAC`, 8, fraction bits of scale factors (Qx.FRAC)

- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `start` in 1: begin a frame; sampled only in IDLE
- `src_w`, `src_h` in DW: source dimensions, ≥1; latched at start
- `dst_w`, `dst_h` in DW: destination dimensions; latched at start
- `scale_x`, `scale_y` in 16: source step per destination pixel, Q(16-FRAC).FRAC; latched at start
- `base_addr` in AW: source image base address; latched at start
- `mem_rd_en` out 1: read strobe
- `mem_addr` out AW: read address
- `mem_rdata` in 8: read data, valid exactly 1 cycle after `mem_rd_en`
- `stg_p00`/`stg_p01`/`stg_p10`/`stg_p11` out 8 x [0:N-1]: staged neighbours, driven to SIMD bank `in_p*`
- `stg_fx`, `stg_fy` out FRAC x [0:N-1]: per-lane fractions
- `lane_valid` out N: lanes holding real pixels
- `simd_ready` in 1: downstream can accept a group
- `load_en` out 1: one-cycle load pulse to SIMD bank
- `busy` out 1: high from start acceptance until `done`
- `done` out 1: one-cycle pulse at frame end

## Operation
- States: IDLE, ROW_SETUP, FETCH, DRAIN, LOAD, ADVANCE, DONE.
- IDLE, `start`=1:
  - Latch configuration; set x0=0, y=0; `busy`=1.
  - If `dst_w`==0 or `dst_h`==0, go to DONE; otherwise go to ROW_SETUP.
- ROW_SETUP, 1 cycle, per output row:
  - sy=y·scale_y; iy=min(sy>>FRAC, src_h-1); iy1=min(iy+1, src_h-1); fy=sy[FRAC-1:0].
  - Register row0=iy·src_w and row1=iy1·src_w.
- FETCH: one read per cycle, one group at a time.
  - Order: lane 0 p00, p01, p10, p11, then lane 1, and so on. Invalid lanes are skipped.
  - Lane i: x=x0+i, valid iff x<dst_w. sx=x·scale_x; ix=min(sx>>FRAC, src_w-1); ix1=min(ix+1, src_w-1); fx=sx[FRAC-1:0].
  - Addresses: p00=base+row0+ix, p01=base+row0+ix1, p10=base+row1+ix, p11=base+row1+ix1.
  - All sums are truncated to AW bits.
  - Returning `mem_rdata` is written to the staging slot of the read issued on the previous cycle.
- DRAIN: 1 cycle; captures the final read datum.
- LOAD:
  - Wait while `simd_ready`=0.
  - When `simd_ready`=1, assert `load_en` for exactly 1 cycle and go to ADVANCE.
  - Staging outputs stay stable from DRAIN exit until the `load_en` cycle inclusive.
- ADVANCE:
  - x0+=N.
  - If x0≥dst_w: x0=0, y+=1. Go to DONE if y==dst_h, else ROW_SETUP.
  - Otherwise go to FETCH.
- DONE: `done`=1 for 1 cycle, `busy`=0, return to IDLE.
- Invalid lanes, in the last partial group of a row: `lane_valid` bit is 0; staging p and fraction values are 0.
- `start` while not IDLE is ignored.
- Reset, including mid-frame, sets these outputs and registers to 0 and returns the FSM to IDLE:
  - `mem_rd_en`, `mem_addr`, `load_en`, `busy`, `done`, `lane_valid`
  - all staging and counter registers

## Timing
- From `start` to the first `mem_rd_en`: 2 cycles (IDLE→ROW_SETUP→FETCH).
- Group with V valid lanes and `simd_ready` held high: 4V FETCH + 1 DRAIN + 1 LOAD + 1 ADVANCE cycles. Add 1 ROW_SETUP cycle at each row start.
- `mem_rd_en` is never asserted outside FETCH and never for invalid lanes.
- `load_en` never coincides with `mem_rd_en`.
- `done` is asserted the cycle after the final ADVANCE. For a zero-dimension frame it is asserted the cycle after `start`.

## Structure
- Shared package `dsa_pkg` holds:
  - `fetch_state_t` enum
  - `FRAC_BITS` and `NB_PER_LANE`=4 constants
  - neighbour index enum (P00, P01, P10, P11)
- Sub-module `dsa_coord_gen`, combinational, instantiated once per axis. Inputs: index, scale, size. Outputs: i0, i1 (clamped), frac.

## Test plan
- Identity, N=4: src 4x4 = dst 4x4, scale 0x0100, memory holds value=addr.
  - Reads per row: 16; `load_en` pulses: 4 total.
  - Lane i, row y: p00=y·4+i, p11=min(y+1,3)·4+min(i+1,3). Fractions are 0.
- Partial group: dst_w=6, dst_h=1, N=4.
  - 2nd group `lane_valid`=4'b0011; exactly 24 reads; invalid lanes stage 0.
- Half scale: src 2x2, dst 4x4, scale 0x0080.
  - Lane 1: fx=0x80, ix=0, ix1=1.
  - Lane 3: ix=1, ix1 clamped to 1.
  - Row 3: iy1 clamped to 1.
- Backpressure: `simd_ready` low for 10 cycles in LOAD.
  - `load_en` stays 0 and staging is stable.
  - `load_en` pulses once, the cycle `simd_ready` rises.
- Zero size: dst_w=0, then `start`. `done` asserts the next cycle; no `mem_rd_en`.
- Reset mid-FETCH: all outputs return to 0 and the FSM is in IDLE. A new `start` runs a frame correctly.
